// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - word handshake into the uart_tx_cfg input FIFO
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with input FIFO and back-to-back frames
module uart_tx_cfg #(
  parameter int CLKRATE    = 25000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_cfg_if.slave                  s,
  output logic                          tx,
  output logic                          busy,
  output logic                          txdone,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV  = CLKRATE / BAUDRATE;
  localparam int BW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  localparam logic [BW-1:0]   BAUD_LAST = BW'(DIV - 1);
  localparam logic [CNTW-1:0] FULL      = CNTW'(FIFO_DEPTH);
  localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [BW-1:0]        baud_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;

  logic                 push;
  logic                 pop;
  logic                 baud_wrap;
  logic                 frame_end;
  logic [DATA_BITS-1:0] head;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // Ready depends only on the registered count, so a full FIFO refuses a push even while popping.
  assign s.tx_ready = (fifo_count < FULL);
  assign push       = s.tx_valid && s.tx_ready;
  assign baud_wrap  = (baud_cnt == BAUD_LAST);
  assign frame_end  = (state == STOP) && baud_wrap && (bit_idx == LAST_STOP);
  assign pop        = (fifo_count != '0) && ((state == IDLE) || frame_end);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s.tx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_count <= fifo_count + CNTW'(push) - CNTW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      txdone   <= 1'b0;
    end else begin
      txdone <= 1'b0;
      if (state != IDLE) begin
        baud_cnt <= baud_wrap ? '0 : baud_cnt + BW'(1);
      end
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg    <= head;
            par_bit  <= parity_of(head);
            baud_cnt <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (baud_wrap) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= PAR;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        PAR: begin
          if (baud_wrap) begin
            tx      <= 1'b1;
            bit_idx <= '0;
            state   <= STOP;
          end
        end
        STOP: begin
          if (baud_wrap) begin
            if (bit_idx == LAST_STOP) begin
              txdone  <= 1'b1;
              bit_idx <= '0;
              // A queued word starts its START bit on this same edge: no idle gap.
              if (pop) begin
                shreg   <= head;
                par_bit <= parity_of(head);
                tx      <= 1'b0;
                state   <= START;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
